baccarat_dealer_fsm: RTL and testbench

- Sequencing controller for one Baccarat round.
- Issues one-hot load strobes to the six card registers (player 1-3, dealer 1-3).
- Consumes the two hand totals computed downstream of those registers and applies the third-card rules.
- Drives the win lights; sits between the card source/registers and the LED/display stage.

---
 rtl/baccarat_pkg.sv | 37 +++
 rtl/baccarat_dealer_fsm_if.sv | 47 ++++
 rtl/banker_draw.sv | 27 ++
 rtl/baccarat_dealer_fsm.sv | 118 +++++++++++
 tb/tb_baccarat_dealer_fsm.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and defaults for the Baccarat round controller.
// Contents: round state enum, 4-bit score/rank types, rule thresholds,
// and the rank-to-card-value mapping used by the third-card table.
package baccarat_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned RANK_W  = 4;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [RANK_W-1:0]  card_rank_t;

  // Default rule thresholds.
  localparam int unsigned NATURAL_MIN_DEF  = 8;
  localparam int unsigned PLAYER_STAND_DEF = 6;

  typedef enum logic [3:0] {
    ST_P1     = 4'd0,
    ST_D1     = 4'd1,
    ST_P2     = 4'd2,
    ST_D2     = 4'd3,
    ST_EVAL   = 4'd4,
    ST_P3     = 4'd5,
    ST_DEC    = 4'd6,
    ST_D3     = 4'd7,
    ST_RESULT = 4'd8,
    ST_DONE   = 4'd9
  } state_e;

  // Ace..9 count face value; 10, J, Q, K and the empty slot (0) count zero.
  function automatic score_t card_value(card_rank_t rank);
    if (rank >= RANK_W'(1) && rank <= RANK_W'(9)) begin
      return SCORE_W'(rank);
    end
    return '0;
  endfunction

endpackage

// File: rtl/baccarat_dealer_fsm_if.sv
// Bus between the dealer controller and its surroundings.
// master: card source / scoring side (drives step, scores, pcard3; sees strobes
// and lights).  slave: the controller itself.
// Optional: BACCARAT_TIE_OUT_EN adds tie_light.
interface baccarat_dealer_fsm_if;
  import baccarat_pkg::*;

  logic       step;
  score_t     pscore;
  score_t     dscore;
  card_rank_t pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;
`ifdef BACCARAT_TIE_OUT_EN
  logic       tie_light;

  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done, tie_light
  );
  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done, tie_light
  );
`else
  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );
  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );
`endif

endinterface

// File: rtl/banker_draw.sv
// Banker third-card table (combinational).
// Ports: dscore - banker two-card total; pcard3 - player third-card rank;
//        draw   - banker takes a third card.
module banker_draw
  import baccarat_pkg::*;
(
  input  score_t     dscore,
  input  card_rank_t pcard3,
  output logic       draw
);

  score_t v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_dealer_fsm.sv
// Sequencing controller for one Baccarat round: issues card-register load
// strobes, applies natural / player / banker third-card rules, drives lights.
// Ports: slow_clock, reset (sync, active-high), bus (slave modport of
// baccarat_dealer_fsm_if: step, pscore, dscore, pcard3 in; load strobes,
// win lights, done out).
// Optional: BACCARAT_TIE_OUT_EN adds a dedicated tie_light output.
module baccarat_dealer_fsm
  import baccarat_pkg::*;
#(
  parameter int unsigned NATURAL_MIN  = NATURAL_MIN_DEF,
  parameter int unsigned PLAYER_STAND = PLAYER_STAND_DEF
) (
  input  logic                  slow_clock,
  input  logic                  reset,
  baccarat_dealer_fsm_if.slave  bus
);

  state_e state_q, state_d;
  logic   player_win_q, player_win_d;
  logic   dealer_win_q, dealer_win_d;
  logic   done_q, done_d;
  logic   tie_q, tie_d;
  logic   banker_draws;
  logic   natural;
  logic   step_ok;

  banker_draw u_banker_draw (
    .dscore (bus.dscore),
    .pcard3 (bus.pcard3),
    .draw   (banker_draws)
  );

  assign natural = (bus.pscore >= SCORE_W'(NATURAL_MIN)) ||
                   (bus.dscore >= SCORE_W'(NATURAL_MIN));

  // Reset wins over step, so no strobe leaks out during a reset cycle.
  assign step_ok = bus.step & ~reset;

  // Next state and registered-output updates.
  always_comb begin
    state_d      = state_q;
    player_win_d = player_win_q;
    dealer_win_d = dealer_win_q;
    done_d       = done_q;
    tie_d        = tie_q;
    if (bus.step) begin
      case (state_q)
        ST_P1:   state_d = ST_D1;
        ST_D1:   state_d = ST_P2;
        ST_P2:   state_d = ST_D2;
        ST_D2:   state_d = ST_EVAL;
        ST_EVAL: begin
          if (natural)                                     state_d = ST_RESULT;
          else if (bus.pscore < SCORE_W'(PLAYER_STAND))    state_d = ST_P3;
          else if (bus.dscore <= SCORE_W'(5))              state_d = ST_D3;
          else                                             state_d = ST_RESULT;
        end
        ST_P3:   state_d = ST_DEC;
        ST_DEC:  state_d = banker_draws ? ST_D3 : ST_RESULT;
        ST_D3:   state_d = ST_RESULT;
        ST_RESULT: begin
          player_win_d = (bus.pscore >= bus.dscore);
          dealer_win_d = (bus.dscore >= bus.pscore);
`ifdef BACCARAT_TIE_OUT_EN
          if (bus.pscore == bus.dscore) begin
            player_win_d = 1'b0;
            dealer_win_d = 1'b0;
            tie_d        = 1'b1;
          end
`endif
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_P1;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q      <= ST_P1;
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
      done_q       <= 1'b0;
      tie_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_win_q <= player_win_d;
      dealer_win_q <= dealer_win_d;
      done_q       <= done_d;
      tie_q        <= tie_d;
    end
  end

  // Mealy load strobes: the card register captures on the edge that leaves X.
  always_comb begin
    bus.load_pcard1 = step_ok && (state_q == ST_P1);
    bus.load_dcard1 = step_ok && (state_q == ST_D1);
    bus.load_pcard2 = step_ok && (state_q == ST_P2);
    bus.load_dcard2 = step_ok && (state_q == ST_D2);
    bus.load_pcard3 = step_ok && (state_q == ST_P3);
    bus.load_dcard3 = step_ok && (state_q == ST_D3);
  end

  assign bus.player_win_light = player_win_q;
  assign bus.dealer_win_light = dealer_win_q;
  assign bus.done             = done_q;
`ifdef BACCARAT_TIE_OUT_EN
  assign bus.tie_light        = tie_q;
`else
  // Tie indication only has a port when the tie output is enabled.
  logic unused_tie;
  assign unused_tie = tie_q;
`endif

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Bench for baccarat_dealer_fsm: directed hands from the rule set plus random
// hands, each checked against a round-level Baccarat model with random step.
module tb_baccarat_dealer_fsm;
  import baccarat_pkg::*;

`ifdef BACCARAT_TIE_OUT_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  // Event codes: index of the strobe bit, or EV_NONE for a step with no strobe.
  localparam int EV_P1 = 0, EV_P2 = 1, EV_P3 = 2, EV_D1 = 3, EV_D2 = 4, EV_D3 = 5;
  localparam int EV_NONE = 6;

  logic slow_clock = 1'b0;
  logic reset      = 1'b1;
  always #5 slow_clock = ~slow_clock;

  baccarat_dealer_fsm_if bif ();

  baccarat_dealer_fsm dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bif)
  );

  int vectors     = 0;
  int miscompares = 0;

  int pc[3];
  int dc[3];
  int rk[6];

  function automatic int cv(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  assign bif.pscore = 4'((cv(pc[0]) + cv(pc[1]) + cv(pc[2])) % 10);
  assign bif.dscore = 4'((cv(dc[0]) + cv(dc[1]) + cv(dc[2])) % 10);
  assign bif.pcard3 = 4'(pc[2]);

  logic [5:0] strb;
  assign strb = {bif.load_dcard3, bif.load_dcard2, bif.load_dcard1,
                 bif.load_pcard3, bif.load_pcard2, bif.load_pcard1};

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit banker_rule(input int ds, input int v);
    case (ds)
      0, 1, 2: return 1'b1;
      3:       return v != 8;
      4:       return v >= 2 && v <= 7;
      5:       return v >= 4 && v <= 7;
      6:       return v == 6 || v == 7;
      default: return 1'b0;
    endcase
  endfunction

  // Card registers: capture on the edge where their strobe was seen high.
  task automatic capture_cards(input logic [5:0] s, input bit rst);
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        if (i < 3) pc[i] <= 0; else dc[i-3] <= 0;
      end else if (s[i]) begin
        if (i < 3) pc[i] <= rk[i]; else dc[i-3] <= rk[i];
      end
    end
  endtask

  // One round: p1,p2,p3,d1,d2,d3 are the ranks the shoe will supply.
  task automatic run_round(input int p1, input int p2, input int p3,
                           input int d1, input int d2, input int d3,
                           input int step_pct, input int abort_at, input bit do_reset);
    int ev[$];
    int ps, ds, idx, cyc, exp_s;
    bit aborted, stepped, rst_seen, exp_p, exp_d, exp_t;
    logic [5:0] s;

    rk[0] = p1; rk[1] = p2; rk[2] = p3; rk[3] = d1; rk[4] = d2; rk[5] = d3;

    // Round-level reference: which steps strobe which card, and the final totals.
    ps = (cv(p1) + cv(p2)) % 10;
    ds = (cv(d1) + cv(d2)) % 10;
    ev = '{EV_P1, EV_D1, EV_P2, EV_D2, EV_NONE};
    if (ps >= 8 || ds >= 8) begin
      ev.push_back(EV_NONE);
    end else if (ps <= 5) begin
      ev.push_back(EV_P3);
      ev.push_back(EV_NONE);
      if (banker_rule(ds, cv(p3))) begin
        ev.push_back(EV_D3);
        ds = (ds + cv(d3)) % 10;
      end
      ps = (ps + cv(p3)) % 10;
      ev.push_back(EV_NONE);
    end else if (ds <= 5) begin
      ev.push_back(EV_D3);
      ds = (ds + cv(d3)) % 10;
      ev.push_back(EV_NONE);
    end else begin
      ev.push_back(EV_NONE);
    end
    exp_t = TIE_EN && (ps == ds);
    exp_p = (ps > ds) || (ps == ds && !TIE_EN);
    exp_d = (ds > ps) || (ps == ds && !TIE_EN);

    if (do_reset) begin
      @(negedge slow_clock);
      reset    = 1'b1;
      bif.step = 1'($urandom_range(0, 1));
      #1;
      check_val("strobe_in_reset", int'(strb), 0);
      @(posedge slow_clock);
      capture_cards('0, 1'b1);
    end

    idx = 0; cyc = 0; aborted = 1'b0;
    while (idx < ev.size() && cyc < 400 && !aborted) begin
      @(negedge slow_clock);
      cyc++;
      check_val("done_mid", int'(bif.done), 0);
      check_val("lights_mid", int'({bif.player_win_light, bif.dealer_win_light}), 0);
`ifdef BACCARAT_TIE_OUT_EN
      check_val("tie_mid", int'(bif.tie_light), 0);
`endif
      reset    = 1'b0;
      bif.step = ($urandom_range(0, 99) < step_pct);
      if (idx == abort_at) begin
        reset    = 1'b1;
        bif.step = 1'b1;
      end
      #1;
      exp_s = (bif.step && !reset && ev[idx] != EV_NONE) ? (1 << ev[idx]) : 0;
      check_val("strobe", int'(strb), exp_s);
      s = strb; stepped = bif.step; rst_seen = reset;
      @(posedge slow_clock);
      capture_cards(s, rst_seen);
      if (rst_seen) aborted = 1'b1;
      else if (stepped) idx++;
    end

    if (aborted) begin
      @(negedge slow_clock);
      reset    = 1'b0;
      bif.step = 1'b0;
      check_val("done_after_abort", int'(bif.done), 0);
      check_val("lights_after_abort",
                int'({bif.player_win_light, bif.dealer_win_light}), 0);
      return;
    end
    check_val("round_steps", idx, ev.size());

    // DONE is absorbing: lights hold and step is ignored.
    repeat (4) begin
      @(negedge slow_clock);
      check_val("done_end", int'(bif.done), 1);
      check_val("player_light", int'(bif.player_win_light), int'(exp_p));
      check_val("dealer_light", int'(bif.dealer_win_light), int'(exp_d));
`ifdef BACCARAT_TIE_OUT_EN
      check_val("tie_light", int'(bif.tie_light), int'(exp_t));
`else
      check_val("tie_both", int'(exp_t), 0);
`endif
      bif.step = 1'($urandom_range(0, 1));
      #1;
      check_val("strobe_done", int'(strb), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pc[i] = 0;
      dc[i] = 0;
    end
    bif.step = 1'b0;
    repeat (2) @(posedge slow_clock);

    // Natural: player 8 vs dealer 3.
    run_round(3, 5, 9, 1, 2, 9, 70, -1, 1'b1);
    // Player 4 draws a 5, dealer 7 stands.
    run_round(2, 2, 5, 3, 4, 9, 70, -1, 1'b1);
    // Dealer 3, player third card 8: stand.
    run_round(1, 1, 8, 1, 2, 4, 70, -1, 1'b1);
    // Dealer 3, player third card Q (value 0): draw.
    run_round(1, 1, 12, 1, 2, 4, 70, -1, 1'b1);
    // Dealer 6, player third card 6: draw.
    run_round(1, 1, 6, 3, 3, 1, 70, -1, 1'b1);
    // Player stands on 7, dealer 5 draws to 7: tie.
    run_round(3, 4, 9, 2, 3, 2, 70, -1, 1'b1);
    // Sparse step: long holds in every state.
    run_round(2, 3, 4, 5, 6, 7, 20, -1, 1'b1);
    // Reset at P3 with step high, then a clean re-deal without extra reset.
    run_round(1, 1, 5, 2, 2, 3, 70, 5, 1'b1);
    run_round(4, 2, 13, 6, 11, 2, 70, -1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      run_round($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                $urandom_range(30, 100), -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
